// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract: one shared full adder processes WIDTH bits LSB first, one per clock.
// Optional SERIAL_ADDSUB_SAT_EN saturates the result to the signed limit on overflow.

module serial_addsub_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

module serial_addsub_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("serial_addsub_seq: WIDTH must be within 2..32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] res_final;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             fa_sum;
  logic             fa_cy;
  logic             ovf_nxt;

  serial_addsub_fa u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .cin   (cy),
    .sum   (fa_sum),
    .carry (fa_cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Sum bit enters at the MSB side; after WIDTH steps the word is LSB-aligned.
  assign res_nxt = {fa_sum, res_sh};
  // The carry flop holds the MSB carry-in during the final step.
  assign ovf_nxt = cy ^ fa_cy;

`ifdef SERIAL_ADDSUB_SAT_EN
  always_comb begin
    res_final = res_nxt;
    if (ovf_nxt) begin
      // a_sh[0] is operand A's MSB on the last step; it gives the true sign.
      res_final = a_sh[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res_final = res_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b ^ {WIDTH{sub}};
      cy   <= sub;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt[WIDTH-1:1];
      cy     <= fa_cy;
      cnt    <= cnt + 1'b1;
      if (last) begin
        result <= res_final;
        cout   <= fa_cy;
        ovf    <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Scoreboard bench for serial_addsub_seq: driver pushes expected results, monitor pops on done.
module tb_serial_addsub_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  serial_addsub_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic is, input int c);
    exp_t   e;
    longint ua, ub, full, sa, sb, t, mx, mn, md;
    md   = longint'(1) << W;
    mx   = (longint'(1) << (W - 1)) - 1;
    mn   = -(longint'(1) << (W - 1));
    ua   = longint'(ia);
    ub   = longint'(ib);
    full = is ? (ua + (md - 1 - ub) + 1) : (ua + ub);
    e.res  = full[W-1:0];
    e.cout = full[W];
    sa = ia[W-1] ? ua - md : ua;
    sb = ib[W-1] ? ub - md : ub;
    t  = is ? (sa - sb) : (sa + sb);
    e.ovf = (t > mx) || (t < mn);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (e.ovf) e.res = (t > 0) ? mx[W-1:0] : mn[W-1:0];
`endif
    e.cyc = c;
    return e;
  endfunction

  // Monitor: compares every done pulse against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      chk("done_consecutive", 64'(prev_done), 64'd0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("cout", 64'(cout), 64'(e.cout));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_done <= done;
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("issue_timeout", 64'(busy), 64'd0);
    a = ia;
    b = ib;
    sub = is;
    start = 1'b1;
    q.push_back(model(ia, ib, is, cyc + 1 + W));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_cout"}, 64'(cout), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_zero("idle");
    end

    // Directed cases; consecutive issues land back-to-back in the DONE cycle.
    issue(4'b0011, 4'b0101, 1'b0);
    issue(4'b0111, 4'b0010, 1'b1);
    issue(4'b0010, 4'b0111, 1'b1);
    issue(4'b1000, 4'b0001, 1'b1);

    // start while busy must be ignored.
    issue(4'b0001, 4'b0010, 1'b0);
    start = 1'b1;
    a = 4'b1111;
    b = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset during bit 2 of a run aborts it.
    issue(4'b0101, 4'b0011, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    issue(4'b0001, 4'b0001, 1'b0);
    drain();

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(W'($urandom), W'($urandom), 1'($urandom));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_addsub_seq.md
Name: serial_addsub_seq

Overview:
- Bit-serial adder/subtractor sequencer built around one internally instantiated 1-bit full adder (sum = a^b^cin; carry = a&b | cin&(a^b)).
- Time-shares that single adder across all WIDTH bit positions, LSB first, one bit per clock.
- Accepts an operand pair on a start strobe and reports result, carry-out and signed overflow with a done pulse.
- Sits beside the parallel ripple adder/subtractor as the area-minimal alternative.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; accepted only when busy=0.
- sub  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result, cout and ovf are valid from this cycle.
- result  output  WIDTH  sum or difference.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: rst_n low forces state IDLE asynchronously. busy=0, done=0, result=0, cout=0, ovf=0, bit counter=0, internal shift registers=0.
- FSM states: IDLE, RUN, DONE.
- Accept: at clock edge k, if start=1 and state is IDLE or DONE:
  - Load the A shift register with a.
  - Load the B shift register with b^{WIDTH{sub}}.
  - Set the carry flop to sub and the counter to 0.
  - Enter RUN; busy=1 from edge k.
- RUN: one bit per edge, at edges k+1 .. k+WIDTH.
  - The adder inputs are A[0], B'[0] and the carry flop.
  - The sum bit shifts into the result register from the MSB side; A and B' shift right; the carry flop takes the adder carry.
  - The counter increments.
  - On the edge where counter = WIDTH-1, the adder carry-in is also captured as the MSB carry-in.
- Completion at edge k+WIDTH:
  - Move to DONE.
  - cout = final carry.
  - ovf = MSB carry-in XOR final carry.
  - busy=0 and done=1 for exactly one cycle.
- Total latency from accept to done is WIDTH+1 edges inclusive; throughput is one operation per WIDTH+1 cycles.
- DONE: if start=1, accept a new operation (back-to-back, no idle cycle) and go to RUN; otherwise go to IDLE. done is never high for two consecutive cycles.
- Holding outputs:
  - result, cout and ovf hold their last values in IDLE and in RUN until the next completion; they are not cleared on accept.
  - result is written only at completion. Shifting uses an internal register; the visible result updates atomically at edge k+WIDTH.
- start while busy=1 is ignored; a, b and sub are not resampled.
- Operand changes after the accept edge have no effect.
- Reset mid-RUN aborts the operation. No done pulse is produced and outputs return to their reset values.
- Arithmetic is modulo 2^WIDTH. Both operands are treated as two's-complement for ovf and as unsigned for cout.

Optional Feature:
- Macro: SERIAL_ADDSUB_SAT_EN.
- Defined: when ovf=1 at completion, result saturates to the signed limit: 0111..1 if the true result was positive (A MSB = 0), 1000..0 if it was negative. cout and ovf are still reported unmodified.
- Undefined: result is always the wrapped modulo-2^WIDTH value. No saturation logic is present.

Test Plan:
- Reset then idle, WIDTH=4 -> busy=0, done=0, result=0000, cout=0, ovf=0; outputs stay static with start=0.
- Add: a=0011, b=0101, sub=0, start at edge k -> done exactly at cycle k+4 edge, result=1000, cout=0, ovf=1. With SAT_EN, result=0111.
- Subtract: a=0111, b=0010, sub=1 -> result=0101, cout=1, ovf=0. Back-to-back start in the DONE cycle with a=0010, b=0111, sub=1 -> next done after 5 more edges, result=1011, cout=0, ovf=0.
- Negative overflow: a=1000, b=0001, sub=1 -> result=0111, ovf=1, cout=1. With SAT_EN, result=1000.
- start pulsed with a=1111, b=1111 while busy -> ignored; the original operation completes with its own result; exactly one done pulse.
- rst_n low for 1 cycle at bit 2 of a run -> outputs zero immediately; no done pulse; a fresh start afterwards completes correctly (0001+0001 -> 0010).
